// File: rtl/argmax_pkg.sv
// Shared types and helpers for the argmax output stage.
// Scores are raw fp32 words; comparison uses a monotonic unsigned key.
package argmax_pkg;

    typedef logic [31:0] fp32_t;
    typedef logic [31:0] key_t;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    localparam fp32_t      FP_NEG_ZERO = 32'h8000_0000;
    localparam logic [7:0] FP_EXP_ALL1 = 8'hFF;

    function automatic logic is_nan(input fp32_t x);
        return (x[30:23] == FP_EXP_ALL1) && (x[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fp32_order_key.sv
// fp32 -> unsigned order key; -0 folds onto +0 so signed zeros tie.
// Combinational, no state, no handshake.
module fp32_order_key
    import argmax_pkg::*;
(
    input  fp32_t fp_i,
    output key_t  key_o,
    output logic  nan_o
);

    fp32_t norm;

    always_comb begin
        norm  = (fp_i == FP_NEG_ZERO) ? 32'h0000_0000 : fp_i;
        key_o = norm[31] ? ~norm : {1'b1, norm[30:0]};
    end

    assign nan_o = is_nan(fp_i);

endmodule

// File: rtl/argmax_stream.sv
// Streaming top-1/top-2 argmax over fp32 class scores, one beat per cycle.
// Result registered on the terminating beat; in_ready drops while a result waits for out_ready.
module argmax_stream
    import argmax_pkg::*;
#(
    parameter int NUM_CLASSES = 10,
    parameter int TOP_K       = 1,
    parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx0,
    output logic [IDX_W-1:0] out_idx1,
    output logic [31:0]      out_score0,
    output logic             out_len_err
);

    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_CLASSES - 1);
    localparam logic [IDX_W-1:0] ONE_CNT  = IDX_W'(1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    // Running leaders; the second's raw bits are never reported, so only its key is kept.
    logic [IDX_W-1:0] best_idx_q, best_idx_d, sec_idx_q, sec_idx_d;
    key_t             best_key_q, best_key_d, sec_key_q, sec_key_d;
    logic             best_nan_q, best_nan_d, sec_nan_q, sec_nan_d;
    fp32_t            best_raw_q, best_raw_d;

    logic [IDX_W-1:0] idx0_q, idx0_d, idx1_q, idx1_d;
    fp32_t            score0_q, score0_d;
    logic             len_err_q, len_err_d;

    key_t in_key;
    logic in_nan;
    logic accept, at_cap, frame_end, gt_best, gt_sec;

    fp32_order_key u_key (
        .fp_i  (in_data),
        .key_o (in_key),
        .nan_o (in_nan)
    );

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign at_cap    = (cnt_q == LAST_CNT);
    assign frame_end = accept && (in_last || at_cap);

    // A NaN never wins; a real score always beats a NaN holder.
    assign gt_best = !in_nan && (best_nan_q || (in_key > best_key_q));
    assign gt_sec  = !in_nan && (sec_nan_q  || (in_key > sec_key_q));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        best_idx_d = best_idx_q;
        best_key_d = best_key_q;
        best_nan_d = best_nan_q;
        best_raw_d = best_raw_q;
        sec_idx_d  = sec_idx_q;
        sec_key_d  = sec_key_q;
        sec_nan_d  = sec_nan_q;
        idx0_d     = idx0_q;
        idx1_d     = idx1_q;
        score0_d   = score0_q;
        len_err_d  = len_err_q;

        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    if (cnt_q == '0) begin
                        best_idx_d = cnt_q;
                        best_key_d = in_key;
                        best_nan_d = in_nan;
                        best_raw_d = in_data;
                        sec_idx_d  = cnt_q;
                        sec_key_d  = in_key;
                        sec_nan_d  = in_nan;
                    end else if (gt_best) begin
                        sec_idx_d  = best_idx_q;
                        sec_key_d  = best_key_q;
                        sec_nan_d  = best_nan_q;
                        best_idx_d = cnt_q;
                        best_key_d = in_key;
                        best_nan_d = in_nan;
                        best_raw_d = in_data;
                    end else if ((cnt_q == ONE_CNT) || gt_sec) begin
                        sec_idx_d  = cnt_q;
                        sec_key_d  = in_key;
                        sec_nan_d  = in_nan;
                    end
                    cnt_d = cnt_q + 1'b1;

                    if (frame_end) begin
                        state_d   = ST_HOLD;
                        cnt_d     = '0;
                        idx0_d    = best_idx_d;
                        idx1_d    = (TOP_K == 2) ? sec_idx_d : '0;
                        score0_d  = best_raw_d;
                        len_err_d = !(in_last && at_cap);
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_ACCUM;
            cnt_q      <= '0;
            best_idx_q <= '0;
            best_key_q <= '0;
            best_nan_q <= 1'b0;
            best_raw_q <= '0;
            sec_idx_q  <= '0;
            sec_key_q  <= '0;
            sec_nan_q  <= 1'b0;
            idx0_q     <= '0;
            idx1_q     <= '0;
            score0_q   <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            best_idx_q <= best_idx_d;
            best_key_q <= best_key_d;
            best_nan_q <= best_nan_d;
            best_raw_q <= best_raw_d;
            sec_idx_q  <= sec_idx_d;
            sec_key_q  <= sec_key_d;
            sec_nan_q  <= sec_nan_d;
            idx0_q     <= idx0_d;
            idx1_q     <= idx1_d;
            score0_q   <= score0_d;
            len_err_q  <= len_err_d;
        end
    end

    assign out_idx0    = idx0_q;
    assign out_idx1    = idx1_q;
    assign out_score0  = score0_q;
    assign out_len_err = len_err_q;

endmodule

// File: tb/tb_argmax_stream.sv
// Randomised and directed frames checked against a whole-frame top-2 reference.
module tb_argmax_stream;

    localparam int N  = 10;
    localparam int IW = $clog2(N);

    logic          clk       = 1'b0;
    logic          resetn    = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_last   = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   in_data   = 32'h0;
    logic          in_ready, out_valid, out_len_err;
    logic [IW-1:0] out_idx0, out_idx1;
    logic [31:0]   out_score0;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] beats [N];

    always #5 clk = ~clk;

    argmax_stream #(.NUM_CLASSES(N), .TOP_K(2)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx0    (out_idx0),
        .out_idx1    (out_idx1),
        .out_score0  (out_score0),
        .out_len_err (out_len_err)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Ranking straight from the ordering rules: NaN below everything, -0 equal to +0.
    function automatic logic [32:0] rank_of(input logic [31:0] x);
        logic [31:0] v;
        if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return 33'd0;
        v = (x == 32'h8000_0000) ? 32'h0 : x;
        return {1'b1, (v[31] ? ~v : {1'b1, v[30:0]})};
    endfunction

    task automatic model(input int n, input bit with_last,
                         output int e0, output int e1, output logic [31:0] es, output bit ee);
        e0 = 0;
        for (int i = 1; i < n; i++)
            if (rank_of(beats[i]) > rank_of(beats[e0])) e0 = i;
        if (n == 1) begin
            e1 = e0;
        end else begin
            e1 = -1;
            for (int i = 0; i < n; i++)
                if (i != e0 && (e1 < 0 || rank_of(beats[i]) > rank_of(beats[e1]))) e1 = i;
        end
        es = beats[e0];
        ee = !(with_last && n == N);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h3F80_0000;
            3: return 32'hBF80_0000;
            4: return 32'h7FC0_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < N; i++) beats[i] = v;
    endtask

    // Called at a negedge; returns at the negedge after the final beat is accepted.
    task automatic send_frame(input string tag, input int n, input bit with_last);
        int waited;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = beats[i];
            in_last  = with_last && (i == n - 1);
            waited = 0;
            while (!in_ready && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (!in_ready) chk_eq({tag, ".ready_timeout"}, 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input int n, input bit with_last);
        int e0, e1;
        logic [31:0] es;
        bit ee;
        model(n, with_last, e0, e1, es, ee);
        chk_eq({tag, ".valid"},    32'(out_valid),   32'd1);
        chk_eq({tag, ".in_ready"}, 32'(in_ready),    32'd0);
        chk_eq({tag, ".idx0"},     32'(out_idx0),    32'(e0));
        chk_eq({tag, ".idx1"},     32'(out_idx1),    32'(e1));
        chk_eq({tag, ".score0"},   out_score0,       es);
        chk_eq({tag, ".len_err"},  32'(out_len_err), 32'(ee));
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk_eq({tag, ".drained"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_frame(input string tag, input int n, input bit with_last);
        send_frame(tag, n, with_last);
        check_result(tag, n, with_last);
        drain(tag);
    endtask

    initial begin
        logic [IW-1:0] h0, h1;
        logic [31:0]   hs;

        repeat (2) @(negedge clk);
        chk_eq("rst.valid",   32'(out_valid),   32'd0);
        chk_eq("rst.ready",   32'(in_ready),    32'd1);
        chk_eq("rst.idx0",    32'(out_idx0),    32'd0);
        chk_eq("rst.idx1",    32'(out_idx1),    32'd0);
        chk_eq("rst.score0",  out_score0,       32'd0);
        chk_eq("rst.len_err", 32'(out_len_err), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        fill(32'h0); beats[3] = 32'h3F80_0000;
        run_frame("one_hot", N, 1'b1);

        fill(32'hBF80_0000); beats[7] = 32'hBF00_0000;
        run_frame("neg_half", N, 1'b1);

        fill(32'h0); beats[2] = 32'h4000_0000; beats[5] = 32'h4000_0000;
        run_frame("tie", N, 1'b1);

        fill(32'hBF80_0000); beats[1] = 32'h8000_0000; beats[6] = 32'h0;
        run_frame("signed_zero", N, 1'b1);

        fill(32'hBF80_0000); beats[0] = 32'h7FC0_0000; beats[4] = 32'h3F80_0000;
        run_frame("nan_first", N, 1'b1);

        fill(32'h7FC0_0000);
        run_frame("all_nan", N, 1'b1);

        fill(32'h0); beats[1] = 32'hBF80_0000; beats[2] = 32'h4040_0000; beats[3] = 32'h3F80_0000;
        run_frame("short", 5, 1'b1);

        fill(32'h3F80_0000); beats[8] = 32'h4000_0000;
        run_frame("no_last", N, 1'b0);

        beats[0] = 32'hC000_0000;
        run_frame("single", 1, 1'b1);

        // Stall: outputs must hold and offered beats must not be consumed.
        for (int i = 0; i < N; i++) beats[i] = pick();
        send_frame("stall", N, 1'b1);
        check_result("stall", N, 1'b1);
        h0 = out_idx0; h1 = out_idx1; hs = out_score0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h7F00_0000;
            in_last  = 1'b1;
            @(negedge clk);
            chk_eq("stall.valid",  32'(out_valid),  32'd1);
            chk_eq("stall.ready",  32'(in_ready),   32'd0);
            chk_eq("stall.idx0",   32'(out_idx0),   32'(h0));
            chk_eq("stall.idx1",   32'(out_idx1),   32'(h1));
            chk_eq("stall.score0", out_score0,      hs);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain("stall");
        fill(32'hBF80_0000); beats[0] = 32'h3F00_0000; beats[9] = 32'h3F00_0000;
        run_frame("post_stall", N, 1'b1);

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < N; i++) beats[i] = 32'h4100_0000;
        send_frame("mid_rst", 4, 1'b0);
        resetn = 1'b0;
        #1;
        chk_eq("mid_rst.valid",  32'(out_valid), 32'd0);
        chk_eq("mid_rst.ready",  32'(in_ready),  32'd1);
        chk_eq("mid_rst.score0", out_score0,     32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        fill(32'h0); beats[6] = 32'h3F80_0000; beats[8] = 32'h3F00_0000;
        run_frame("after_rst", N, 1'b1);

        for (int f = 0; f < 40; f++) begin
            int  kind, n;
            bit  wl;
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                n = $urandom_range(1, N - 1); wl = 1'b1;
            end else if (kind == 1) begin
                n = N; wl = 1'b0;
            end else begin
                n = N; wl = 1'b1;
            end
            for (int i = 0; i < N; i++) beats[i] = pick();
            run_frame($sformatf("rand%0d", f), n, wl);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
